// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: the operand is split into STAGES slices, one slice is added per stage,
// and the carry ripples between stages through registers. Upper operands are skewed, lower sums deskewed.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SW = WIDTH / STAGES;

  if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64 || STAGES < 1 || STAGES > 8 ||
      (WIDTH % (4 * STAGES)) != 0) begin : g_bad_params
    $error("pipelined_add_sub: illegal WIDTH/STAGES combination");
  end

  // Adds one slice using 4-bit lookahead groups.
  // Returns {carry_out, carry_into_msb, sum}.
  function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          ci);
    logic [SW-1:0] s;
    logic [3:0]    p;
    logic [3:0]    g;
    logic [4:0]    cc;
    logic          c;
    logic          cm;
    s  = '0;
    c  = ci;
    cm = 1'b0;
    for (int i = 0; i < SW / 4; i++) begin
      p     = x[i*4 +: 4] ^ y[i*4 +: 4];
      g     = x[i*4 +: 4] & y[i*4 +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
              (p[3] & p[2] & p[1] & p[0] & c);
      s[i*4 +: 4] = p ^ cc[3:0];
      cm = cc[3];
      c  = cc[4];
    end
    return {c, cm, s};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // op[0] selects subtraction (invert b); op[1] selects the external carry-in.
  assign b_eff   = op[0] ? ~b : b;
  assign c_first = op[1] ? cin : op[0];

  // acc holds finished sum slices below the current stage and untouched a slices above it.
  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic             cm_q  [STAGES];
  logic             zr_q  [STAGES];
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];

  logic             vld_d [STAGES];
  logic             cy_d  [STAGES];
  logic             cm_d  [STAGES];
  logic             zr_d  [STAGES];
  logic [WIDTH-1:0] acc_d [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [SW+1:0]    sr    [STAGES];

  always_comb begin
    sr[0]              = slice_add(a[SW-1:0], b_eff[SW-1:0], c_first);
    acc_d[0]           = a;
    acc_d[0][SW-1:0]   = sr[0][SW-1:0];
    opb_d[0]           = b_eff;
    vld_d[0]           = in_valid;
    cy_d[0]            = sr[0][SW+1];
    cm_d[0]            = sr[0][SW];
    zr_d[0]            = (sr[0][SW-1:0] == '0);
    for (int k = 1; k < STAGES; k++) begin
      sr[k]               = slice_add(acc_q[k-1][k*SW +: SW], opb_q[k-1][k*SW +: SW], cy_q[k-1]);
      acc_d[k]            = acc_q[k-1];
      acc_d[k][k*SW +: SW] = sr[k][SW-1:0];
      opb_d[k]            = opb_q[k-1];
      vld_d[k]            = vld_q[k-1];
      cy_d[k]             = sr[k][SW+1];
      cm_d[k]             = sr[k][SW];
      zr_d[k]             = zr_q[k-1] & (sr[k][SW-1:0] == '0);
    end
  end

  // Whole pipeline moves together; clr wins over any accept.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        cm_q[k]  <= 1'b0;
        zr_q[k]  <= 1'b0;
        acc_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        cy_q[k]  <= cy_d[k];
        cm_q[k]  <= cm_d[k];
        zr_q[k]  <= zr_d[k];
        acc_q[k] <= acc_d[k];
        opb_q[k] <= opb_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = acc_q[STAGES-1];
  assign flags     = {acc_q[STAGES-1][WIDTH-1], zr_q[STAGES-1], cy_q[STAGES-1],
                      cm_q[STAGES-1] ^ cy_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench: four instances (STAGES 1,2,4,8) share stimulus; each has its own scoreboard queue.
// Directed checks target the STAGES=4 instance (index 2).
module tb_pipelined_add_sub;

  localparam int W = 32;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic          out_ready;
  logic          cin;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  logic [N-1:0]  in_ready_w;
  logic [N-1:0]  out_valid_w;
  logic [W-1:0]  result_w [N];
  logic [3:0]    flags_w  [N];

  logic [35:0]   sbq [N][$];
  int            acc_cnt [N];
  int            total = 0;
  int            bad   = 0;
  logic          acc2;
  logic          pop2;
  logic [31:0]   pop2_res;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipelined_add_sub #(.WIDTH(W), .STAGES(1 << g)) dut (
      .clk      (clk),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready_w[g]),
      .op       (op),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready),
      .result   (result_w[g]),
      .flags    (flags_w[g])
    );
  end

  // Reference: {N,Z,C,V,result}; V from operand/result signs.
  function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic c);
    logic [31:0] yy;
    logic        ci;
    logic [32:0] s;
    logic [31:0] r;
    logic        v;
    yy = o[0] ? ~y : y;
    ci = o[1] ? c : o[0];
    s  = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
    r  = s[31:0];
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {r[31], (r == 32'd0), s[32], v, r};
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [35:0] e;
    acc2 = 1'b0;
    pop2 = 1'b0;
    for (int d = 0; d < N; d++) begin
      if (out_valid_w[d] && out_ready) begin
        checkVal($sformatf("sb_pending_s%0d", 1 << d), 64'(sbq[d].size() > 0), 64'd1);
        if (sbq[d].size() > 0) begin
          e = sbq[d].pop_front();
          checkVal($sformatf("sb_result_s%0d", 1 << d), 64'({flags_w[d], result_w[d]}), 64'(e));
          if (d == 2) begin
            pop2     = 1'b1;
            pop2_res = result_w[d];
          end
        end
      end
      if (in_valid && in_ready_w[d]) begin
        sbq[d].push_back(model(op, a, b, cin));
        acc_cnt[d]++;
        if (d == 2) acc2 = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic c, input logic ordy);
    @(negedge clk);
    clr       = 1'b0;
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, ordy);
  endtask

  task automatic doClear(input logic v, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    clr       = 1'b1;
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    cin       = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < N; d++) sbq[d].delete();
  endtask

  task automatic runOne(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic c, input logic [31:0] exp_res,
                        input logic [3:0] exp_flg);
    applyStimulus(1'b1, o, x, y, c, 1'b1);
    checkVal({tag, "_accept"}, 64'(acc2), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1);
      checkVal($sformatf("%s_valid_c%0d", tag, i), 64'(out_valid_w[2]), 64'(i == 4));
    end
    checkVal({tag, "_result"}, 64'(result_w[2]), 64'(exp_res));
    checkVal({tag, "_flags"}, 64'(flags_w[2]), 64'(exp_flg));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   nxt;
    int   seen;
    int   cyc;
    logic done;

    clr = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < N; d++) acc_cnt[d] = 0;
    repeat (2) @(posedge clk);

    // Operation presented together with clr must vanish.
    doClear(1'b1, 2'b00, 32'h1234, 32'h1);
    idle(1'b0);
    checkVal("rst_in_ready", 64'(in_ready_w[2]), 64'd1);
    checkVal("rst_out_valid", 64'(out_valid_w[2]), 64'd0);
    checkVal("rst_result", 64'(result_w[2]), 64'd0);
    checkVal("rst_flags", 64'(flags_w[2]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      checkVal("clr_discard_valid", 64'(out_valid_w[2]), 64'd0);
    end

    runOne("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001);
    runOne("sub_eq", 2'b01, 32'd5, 32'd5, 1'b0, 32'h00000000, 4'b0110);
    runOne("sub_neg", 2'b01, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 4'b1000);
    runOne("adc_wrap", 2'b10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110);
    runOne("sbb", 2'b11, 32'h10, 32'h01, 1'b0, 32'h0000000E, 4'b0010);

    // Back-to-back i+i with a five-cycle consumer stall once the first result shows.
    nxt  = 1;
    seen = 0;
    for (int s = 0; s < 25; s++) begin
      applyStimulus(nxt <= 6, 2'b00, 32'(nxt), 32'(nxt), 1'b0, !(s >= 4 && s <= 8));
      if (acc2) nxt++;
      if (pop2) begin
        checkVal($sformatf("stall_order_%0d", seen), 64'(pop2_res), 64'(2 * (seen + 1)));
        seen++;
      end
      if (s >= 4 && s <= 8) begin
        checkVal("stall_in_ready", 64'(in_ready_w[2]), 64'd0);
        checkVal("stall_hold_valid", 64'(out_valid_w[2]), 64'd1);
        checkVal("stall_hold_result", 64'(result_w[2]), 64'd2);
        checkVal("stall_hold_flags", 64'(flags_w[2]), 64'd0);
      end
    end
    checkVal("stall_count", 64'(seen), 64'd6);

    // Flush three in-flight operations.
    for (int s = 0; s < 3; s++) applyStimulus(1'b1, 2'b00, 32'(100 + s), 32'(s), 1'b0, 1'b1);
    doClear(1'b0, 2'b00, 32'd0, 32'd0);
    for (int j = 1; j <= 4; j++) begin
      idle(1'b1);
      if (j == 1) checkVal("flush_in_ready", 64'(in_ready_w[2]), 64'd1);
      checkVal($sformatf("flush_valid_c%0d", j), 64'(out_valid_w[2]), 64'd0);
    end
    runOne("post_flush", 2'b00, 32'd1, 32'd1, 1'b0, 32'd2, 4'b0000);

    // Random traffic against every pipeline depth.
    doClear(1'b0, 2'b00, 32'd0, 32'd0);
    for (int d = 0; d < N; d++) acc_cnt[d] = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 60000) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      cyc++;
      done = 1'b1;
      for (int d = 0; d < N; d++) if (acc_cnt[d] < 10000) done = 1'b0;
    end
    checkVal("rand_budget", 64'(done), 64'd1);
    repeat (12) idle(1'b1);
    for (int d = 0; d < N; d++)
      checkVal($sformatf("rand_drained_s%0d", 1 << d), 64'(sbq[d].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; legal values: multiple of 4, 8..64.
REQ-002 The block SHALL have parameter STAGES, default 4, pipeline depth; legal values: 1..8, with WIDTH divisible by 4*STAGES.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port clr  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operands present this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 The block SHALL have port op  input  2  operation select: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-008 The block SHALL have port a, b  input  WIDTH  operands.
REQ-009 The block SHALL have port cin  input  1  carry-in, used only by ADC/SBB.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 The block SHALL have port result  output  WIDTH  sum/difference.
REQ-013 The block SHALL have port flags  output  4  {N, Z, C, V}.

Function
REQ-014 Effective operands SHALL be: ADD a + b + 0; SUB a + ~b + 1; ADC a + b + cin; SBB a + ~b + cin (cin=1 means no borrow).
REQ-015 The datapath SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k using 4-bit carry-lookahead groups, rippling carry between groups within the slice.
REQ-016 Carry out of slice k SHALL be registered and used as carry in of slice k+1 one cycle later.
REQ-017 Unprocessed upper operand slices SHALL be skewed through registers; completed lower result slices SHALL be deskewed through registers, so that every result bit emerges in the same cycle.
REQ-018 Latency SHALL be exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, with no stall.
REQ-019 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-020 Pipeline advance SHALL be global: adv = ~out_valid | out_ready; in_ready SHALL equal adv; all stage registers SHALL hold when adv=0.
REQ-021 Each stage SHALL carry a valid bit; an empty input slot (in_valid=0 while adv=1) SHALL propagate as a bubble.
REQ-022 result, flags and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Flag C SHALL be the carry out of the MSB (for SUB/SBB: 1 means no borrow).
REQ-024 Flag V SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-025 Flag N SHALL be result[WIDTH-1].
REQ-026 Flag Z SHALL be 1 iff result == 0; it SHALL be accumulated per slice so that no WIDTH-wide reduction follows the final adder.
REQ-027 Results SHALL emerge in acceptance order; no operation SHALL be dropped or duplicated under any out_ready pattern.
REQ-028 With STAGES=1, the block SHALL reduce to a single registered full-width add, with latency 1.

Reset
REQ-029 While clr=1 at a clock edge, all valid bits SHALL clear; out_valid, result and flags SHALL be 0 the following cycle.
REQ-030 clr SHALL take priority over acceptance: an operation presented in the same cycle as clr SHALL be discarded.
REQ-031 Operations in flight when clr asserts SHALL be flushed and never appear at the output.
REQ-032 in_ready SHALL be 1 in the first cycle after clr deasserts.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-033 The bench SHALL check: ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, N=1 Z=0 C=0 V=1, out_valid exactly 4 cycles after acceptance.
REQ-034 The bench SHALL check: SUB 5 - 5 -> 0x00000000, Z=1 C=1 N=0 V=0; and SUB 3 - 5 -> 0xFFFFFFFE, N=1 C=0 V=0.
REQ-035 The bench SHALL check: ADC 0xFFFFFFFF + 0x00000000, cin=1 -> 0x00000000, C=1 Z=1; and SBB 0x10 - 0x01, cin=0 -> 0x0000000E, C=1.
REQ-036 The bench SHALL check: 6 back-to-back ADDs i + i (i=1..6) with out_ready=0 for 5 cycles after the first result appears -> in_ready=0 during the stall, held output constant, then results 2, 4, 6, 8, 10, 12 in order.
REQ-037 The bench SHALL check: 3 ops in flight, clr pulsed 1 cycle -> out_valid=0 for the next 4 cycles, and a following ADD 1 + 1 returns 2 after 4 cycles.
REQ-038 The bench SHALL run 10k random ops with random op, cin, in_valid and out_ready at STAGES = 1, 2, 4, 8, comparing result and flags against a reference model.
